arduino_adc_stepper_drv: RTL and testbench

Half-step stepper-motor sequencer that directly consumes the 4-bit motor command word produced by the Avalon PIO "Motor" port. It decodes the command into enable, direction and a speed code. It times steps with a programmable divider and drives four coil outputs through an 8-state half-step sequence. It also keeps a signed step-position count and applies a timed holding-torque phase on stop.

---
 rtl/arduino_adc_motor_pkg.sv | 36 +++
 rtl/arduino_adc_step_timer.sv | 27 ++
 rtl/arduino_adc_stepper_drv.sv | 161 ++++++++++++++++
 tb/tb_arduino_adc_stepper_drv.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/arduino_adc_motor_pkg.sv
// Shared types and helpers for the half-step stepper sequencer.
package arduino_adc_motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int unsigned CMD_W      = 4;
  localparam int unsigned CMD_EN     = 0;
  localparam int unsigned CMD_DIR    = 1;
  localparam int unsigned CMD_SPD_LO = 2;
  localparam int unsigned CMD_SPD_HI = 3;

  localparam int unsigned COIL_W = 4;
  localparam int unsigned POS_W  = 16;
  localparam int unsigned IDX_W  = 3;

  // Coil pattern {D,C,B,A} for each half-step position.
  function automatic logic [COIL_W-1:0] half_step_coil(input logic [IDX_W-1:0] idx);
    logic [COIL_W-1:0] pat;
    case (idx)
      3'd0:    pat = 4'b0001;
      3'd1:    pat = 4'b0011;
      3'd2:    pat = 4'b0010;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0100;
      3'd5:    pat = 4'b1100;
      3'd6:    pat = 4'b1000;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/arduino_adc_step_timer.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module arduino_adc_step_timer #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_load,
  input  logic             i_en,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/arduino_adc_stepper_drv.sv
// Half-step stepper sequencer driven by the PIO motor command word, with
// position tracking and a timed holding-torque phase after stop.
module arduino_adc_stepper_drv
  import arduino_adc_motor_pkg::*;
#(
  parameter int unsigned BASE_DIV    = 50000,
  parameter int unsigned HOLD_CYCLES = 500000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CMD_W-1:0]  motor_cmd,
  output logic [COIL_W-1:0] coil,
  output logic [POS_W-1:0]  position,
  output logic              moving
);

  localparam logic [CNT_W-1:0] PER3_M1   = CNT_W'(BASE_DIV - 1);
  localparam logic [CNT_W-1:0] PER2_M1   = CNT_W'(2 * BASE_DIV - 1);
  localparam logic [CNT_W-1:0] PER1_M1   = CNT_W'(4 * BASE_DIV - 1);
  localparam logic [CNT_W-1:0] PER0_M1   = CNT_W'(8 * BASE_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_t            r_state;
  state_t            w_state_nx;
  logic [CMD_W-1:0]  r_cmd_q;
  logic [COIL_W-1:0] r_coil;
  logic [COIL_W-1:0] w_coil_nx;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nx;
  logic [POS_W-1:0]  r_position;
  logic [POS_W-1:0]  w_position_nx;
  logic              r_moving;
  logic              w_moving_nx;

  logic [1:0]        w_spd;
  logic              w_en;
  logic              w_dir;
  logic [CNT_W-1:0]  w_per_val;
  logic              w_per_load;
  logic              w_per_en;
  logic              w_per_zero_c;
  logic              w_hold_load;
  logic              w_hold_en;
  logic              w_hold_zero_c;

  assign w_en  = r_cmd_q[CMD_EN];
  assign w_dir = r_cmd_q[CMD_DIR];
  assign w_spd = r_cmd_q[CMD_SPD_HI:CMD_SPD_LO];

  // Period reload always reflects the latest command, so speed changes land on a step boundary.
  always_comb begin
    w_per_val = PER0_M1;
    case (w_spd)
      2'd3:    w_per_val = PER3_M1;
      2'd2:    w_per_val = PER2_M1;
      2'd1:    w_per_val = PER1_M1;
      default: w_per_val = PER0_M1;
    endcase
  end

  arduino_adc_step_timer #(.CNT_W(CNT_W)) u_period_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load_val (w_per_val),
    .i_load     (w_per_load),
    .i_en       (w_per_en),
    .o_zero_c   (w_per_zero_c)
  );

  arduino_adc_step_timer #(.CNT_W(CNT_W)) u_hold_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load_val (HOLD_LOAD),
    .i_load     (w_hold_load),
    .i_en       (w_hold_en),
    .o_zero_c   (w_hold_zero_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cmd_q    <= '0;
      r_coil     <= '0;
      r_idx      <= '0;
      r_position <= '0;
      r_moving   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cmd_q    <= motor_cmd;
      r_coil     <= w_coil_nx;
      r_idx      <= w_idx_nx;
      r_position <= w_position_nx;
      r_moving   <= w_moving_nx;
    end
  end

  // Disable takes priority over a coincident step; enable takes priority over hold expiry.
  always_comb begin
    w_state_nx    = r_state;
    w_coil_nx     = r_coil;
    w_idx_nx      = r_idx;
    w_position_nx = r_position;
    w_per_load    = 1'b0;
    w_per_en      = 1'b0;
    w_hold_load   = 1'b0;
    w_hold_en     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_coil_nx = '0;
        if (w_en) begin
          w_state_nx = ST_RUN;
          w_coil_nx  = half_step_coil(r_idx);
          w_per_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (!w_en) begin
          if (HOLD_CYCLES == 0) begin
            w_state_nx = ST_IDLE;
            w_coil_nx  = '0;
          end else begin
            w_state_nx  = ST_HOLD;
            w_hold_load = 1'b1;
          end
        end else if (w_per_zero_c) begin
          w_idx_nx      = w_dir ? r_idx + IDX_W'(1) : r_idx - IDX_W'(1);
          w_position_nx = w_dir ? r_position + POS_W'(1) : r_position - POS_W'(1);
          w_coil_nx     = half_step_coil(w_idx_nx);
          w_per_load    = 1'b1;
        end else begin
          w_per_en = 1'b1;
        end
      end
      ST_HOLD: begin
        w_coil_nx = half_step_coil(r_idx);
        if (w_en) begin
          w_state_nx = ST_RUN;
          w_per_load = 1'b1;
        end else if (w_hold_zero_c) begin
          w_state_nx = ST_IDLE;
          w_coil_nx  = '0;
        end else begin
          w_hold_en = 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_coil_nx  = '0;
      end
    endcase

    w_moving_nx = (w_state_nx == ST_RUN);
  end

  assign coil     = r_coil;
  assign position = r_position;
  assign moving   = r_moving;

endmodule

// File: tb/tb_arduino_adc_stepper_drv.sv
// Scoreboard bench: every expected output change is queued with its cycle and
// matched in order against observed changes of {coil, position, moving}.
module tb_arduino_adc_stepper_drv;

  typedef struct {
    string       tag;
    int          cyc;
    logic [3:0]  coil;
    logic [15:0] pos;
    logic        mov;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  motor_cmd;
  logic [3:0]  coil;
  logic [15:0] position;
  logic        moving;

  int          cyc;
  int          n_checks;
  int          n_errors;
  bit          mon_en;
  logic [20:0] mon_now;
  logic [20:0] mon_prev;
  exp_t        mon_e;
  exp_t        sb[$];
  logic [3:0]  tbl[8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                          4'b0100, 4'b1100, 4'b1000, 4'b1001};

  arduino_adc_stepper_drv #(
    .BASE_DIV    (4),
    .HOLD_CYCLES (10),
    .CNT_W       (20)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .motor_cmd (motor_cmd),
    .coil      (coil),
    .position  (position),
    .moving    (moving)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input string tag, input int c, input logic [3:0] cl,
                      input logic [15:0] p, input logic m);
    exp_t e;
    e.tag = tag; e.cyc = c; e.coil = cl; e.pos = p; e.mov = m;
    sb.push_back(e);
  endtask

  // Observe output changes at the falling edge and retire queued expectations.
  always @(negedge clk) begin
    mon_now = {coil, position, moving};
    if (mon_en && (mon_now !== mon_prev)) begin
      if (sb.size() == 0) begin
        check("unexpected_change", 32'(mon_now), 32'(mon_prev));
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_cyc"},  32'(cyc),      32'(mon_e.cyc));
        check({mon_e.tag, "_coil"}, 32'(coil),     32'(mon_e.coil));
        check({mon_e.tag, "_pos"},  32'(position), 32'(mon_e.pos));
        check({mon_e.tag, "_mov"},  32'(moving),   32'(mon_e.mov));
      end
    end
    mon_prev = mon_now;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    motor_cmd = 4'b0000;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_checks  = 0;
    n_errors  = 0;
    mon_en    = 1'b0;
    mon_prev  = '0;
    motor_cmd = 4'b0000;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_coil", 32'(coil), 32'd0);
    check("rst_pos",  32'(position), 32'd0);
    check("rst_mov",  32'(moving), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("idle_out", 32'({coil, position, moving}), 32'd0);
    end

    // Forward run, then mid-period speed drop to code 0, then stop into hold.
    k = cyc;
    motor_cmd = 4'b1111;
    push("fwd_en", k + 2, tbl[0], 16'd0, 1'b1);
    for (int i = 1; i <= 8; i++)
      push($sformatf("fwd%0d", i), k + 2 + 4 * i, tbl[i % 8], 16'(i), 1'b1);
    wait_until(k + 36);
    motor_cmd = 4'b0011;
    push("spd9",  k + 38,  tbl[1], 16'd9,  1'b1);
    push("spd10", k + 70,  tbl[2], 16'd10, 1'b1);
    push("spd11", k + 102, tbl[3], 16'd11, 1'b1);
    wait_until(k + 102);
    motor_cmd = 4'b0000;
    push("hold1",     k + 104, tbl[3], 16'd11, 1'b0);
    push("hold1_clr", k + 114, 4'b0000, 16'd11, 1'b0);
    drain(60);

    // Restart from idle, stop, and resume from hold without an extra step.
    k = cyc;
    motor_cmd = 4'b1111;
    push("re_en", k + 2, tbl[3], 16'd11, 1'b1);
    wait_until(k + 3);
    motor_cmd = 4'b0000;
    push("stop2", k + 5, tbl[3], 16'd11, 1'b0);
    wait_until(k + 8);
    motor_cmd = 4'b1111;
    push("resume",      k + 10, tbl[3], 16'd11, 1'b1);
    push("resume_step", k + 14, tbl[4], 16'd12, 1'b1);
    wait_until(k + 14);
    motor_cmd = 4'b0000;
    push("hold3",     k + 16, tbl[4], 16'd12, 1'b0);
    push("hold3_clr", k + 26, 4'b0000, 16'd12, 1'b0);
    drain(40);

    // Reverse from reset wraps position below zero.
    do_reset();
    k = cyc;
    motor_cmd = 4'b1101;
    push("rev_en", k + 2,  tbl[0], 16'h0000, 1'b1);
    push("rev1",   k + 6,  tbl[7], 16'hFFFF, 1'b1);
    push("rev2",   k + 10, tbl[6], 16'hFFFE, 1'b1);
    wait_until(k + 10);
    motor_cmd = 4'b0000;
    push("rev_hold", k + 12, tbl[6], 16'hFFFE, 1'b0);
    push("rev_clr",  k + 22, 4'b0000, 16'hFFFE, 1'b0);
    drain(40);

    // Asynchronous reset in the middle of a run.
    do_reset();
    k = cyc;
    motor_cmd = 4'b1111;
    push("mr_en", k + 2, tbl[0], 16'd0, 1'b1);
    for (int i = 1; i <= 5; i++)
      push($sformatf("mr%0d", i), k + 2 + 4 * i, tbl[i], 16'(i), 1'b1);
    drain(40);
    check("mr_pre_pos", 32'(position), 32'd5);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mr_coil", 32'(coil), 32'd0);
    check("mr_pos",  32'(position), 32'd0);
    check("mr_mov",  32'(moving), 32'd0);
    motor_cmd = 4'b0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_rst", 32'({coil, position, moving}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
